// File: rtl/bram_sweep_reader_pkg.sv
// bram_sweep_pkg: shared types and helpers for the BRAM sweep read checker.
//   sweep_state_e  : reader FSM states
//   ERR_WID_DEF    : default mismatch counter width
//   expected_word(): checkerboard pattern word for a given address LSB
package bram_sweep_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } sweep_state_e;

  localparam int ERR_WID_DEF = 16;

  // Widest data word the pattern helper can produce; callers cast down to D_WID.
  localparam int D_WID_MAX = 64;

  // Every bit of the word equals addr_lsb ^ inv (all-zeros or all-ones).
  function automatic logic [D_WID_MAX-1:0] expected_word(input logic addr_lsb,
                                                          input logic inv);
    return {D_WID_MAX{addr_lsb ^ inv}};
  endfunction

endpackage

// File: rtl/bram_sweep_reader_if.sv
// bram_sweep_reader_if: single BRAM read port.
//   rd_en   : read enable (reader -> memory)
//   rd_addr : read address (reader -> memory)
//   rd_dout : read data, valid RD_LAT cycles after issue (memory -> reader)
interface bram_sweep_reader_if #(
  parameter int A_WID = 12,
  parameter int D_WID = 36
);
  logic             rd_en;
  logic [A_WID-1:0] rd_addr;
  logic [D_WID-1:0] rd_dout;

  modport master (output rd_en, output rd_addr, input rd_dout);
  modport slave  (input rd_en, input rd_addr, output rd_dout);
endinterface

// File: rtl/bram_sweep_reader_tag_pipe.sv
// bram_rd_tag_pipe: RD_LAT-deep shift register of {valid, addr} that tracks
// reads in flight so each returning word can be matched to its address.
//   clk, clr       : clock, synchronous clear of all stages
//   in_vld/in_addr : tag of the read visible on the memory port this cycle
//   out_vld/out_addr : tag whose data is on rd_dout this cycle
//   pend           : some tag will still be in flight after this clock edge
module bram_rd_tag_pipe #(
  parameter int A_WID  = 12,
  parameter int RD_LAT = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_vld,
  input  logic [A_WID-1:0] in_addr,
  output logic             out_vld,
  output logic [A_WID-1:0] out_addr,
  output logic             pend
);

  logic [RD_LAT-1:0] vld_q;
  logic [A_WID-1:0]  addr_q [RD_LAT];

  always_ff @(posedge clk) begin
    if (clr) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) addr_q[i] <= '0;
    end else begin
      vld_q[0]  <= in_vld;
      addr_q[0] <= in_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  assign out_vld  = vld_q[RD_LAT-1];
  assign out_addr = addr_q[RD_LAT-1];

  // The last stage is consumed this cycle, so only the input and the inner
  // stages count as still pending.
  always_comb begin
    pend = in_vld;
    for (int i = 0; i < RD_LAT - 1; i++) pend = pend | vld_q[i];
  end

endmodule

// File: rtl/bram_sweep_reader.sv
// bram_sweep_reader: sweeps ADDR_FIRST..ADDR_LAST through one BRAM read port
// and checks every word against the address-parity checkerboard.
//   clk, rst             : clock, synchronous active-high reset
//   dut_start            : level start request (re-arm needs a low phase)
//   dut_enable           : 0 stalls read issue
//   pat_inv              : pattern polarity, latched at sweep start
//   mem                  : BRAM read port (master side)
//   busy/done/pass       : sweep status
//   err_cnt              : saturating mismatch count
//   fail_valid/addr/data : first mismatch record
// D_WID must not exceed bram_sweep_pkg::D_WID_MAX.
//
// state   | meaning
// S_IDLE  | waiting for dut_start, no reads
// S_SWEEP | issuing one read per enabled cycle
// S_DRAIN | all reads issued, waiting for the tag pipe to empty
// S_DONE  | results valid, waiting for dut_start to drop
module bram_sweep_reader
  import bram_sweep_pkg::*;
#(
  parameter int ID         = 0,
  parameter int A_WID      = 12,
  parameter int D_WID      = 36,
  parameter int RD_LAT     = 2,
  parameter int ADDR_FIRST = 0,
  parameter int ADDR_LAST  = 2**A_WID - 1,
  parameter int ERR_WID    = ERR_WID_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dut_start,
  input  logic               dut_enable,
  input  logic               pat_inv,
  bram_sweep_reader_if.master mem,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_WID-1:0] err_cnt,
  output logic               fail_valid,
  output logic [A_WID-1:0]   fail_addr,
  output logic [D_WID-1:0]   fail_data
);

  localparam logic [A_WID-1:0] FIRST_A = A_WID'(ADDR_FIRST);
  localparam logic [A_WID-1:0] LAST_A  = A_WID'(ADDR_LAST);

  sweep_state_e       state_q;
  logic               rd_en_q, inv_q, busy_q, done_q, pass_q;
  logic [A_WID-1:0]   rd_addr_q, addr_q;
  logic [ERR_WID-1:0] err_cnt_q, err_cnt_d;
  logic               fail_valid_q, fail_valid_d;
  logic [A_WID-1:0]   fail_addr_q, fail_addr_d;
  logic [D_WID-1:0]   fail_data_q, fail_data_d;

  logic               tag_vld, pend;
  logic [A_WID-1:0]   tag_addr;
  logic [D_WID-1:0]   exp_word;
  logic               mismatch, issue;
  logic [A_WID-1:0]   issue_addr;

  // The tag enters the pipe in the cycle the read is visible on the port,
  // so its last stage lines up with rd_dout RD_LAT cycles later.
  bram_rd_tag_pipe #(.A_WID(A_WID), .RD_LAT(RD_LAT)) u_tag_pipe (
    .clk      (clk),
    .clr      (rst),
    .in_vld   (rd_en_q),
    .in_addr  (rd_addr_q),
    .out_vld  (tag_vld),
    .out_addr (tag_addr),
    .pend     (pend)
  );

  always_comb begin
    exp_word     = D_WID'(expected_word(tag_addr[0], inv_q));
    mismatch     = tag_vld && (mem.rd_dout != exp_word);
    err_cnt_d    = err_cnt_q;
    fail_valid_d = fail_valid_q;
    fail_addr_d  = fail_addr_q;
    fail_data_d  = fail_data_q;
    if (mismatch) begin
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_WID'(1);
      if (!fail_valid_q) begin
        fail_valid_d = 1'b1;
        fail_addr_d  = tag_addr;
        fail_data_d  = mem.rd_dout;
      end
    end
    // The start cycle already issues the first read so it shows up one
    // cycle after dut_start is sampled.
    issue      = dut_enable &&
                 ((state_q == S_IDLE && dut_start) || state_q == S_SWEEP);
    issue_addr = (state_q == S_IDLE) ? FIRST_A : addr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      addr_q       <= '0;
      inv_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_cnt_q    <= '0;
      fail_valid_q <= 1'b0;
      fail_addr_q  <= '0;
      fail_data_q  <= '0;
    end else begin
      rd_en_q      <= 1'b0;
      err_cnt_q    <= err_cnt_d;
      fail_valid_q <= fail_valid_d;
      fail_addr_q  <= fail_addr_d;
      fail_data_q  <= fail_data_d;

      case (state_q)
        S_IDLE: begin
          if (dut_start) begin
            inv_q        <= pat_inv;
            addr_q       <= FIRST_A;
            err_cnt_q    <= '0;
            fail_valid_q <= 1'b0;
            fail_addr_q  <= '0;
            fail_data_q  <= '0;
            pass_q       <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= S_SWEEP;
          end
        end
        S_SWEEP: ;
        S_DRAIN: begin
          // The final compare happens on this same edge, so err_cnt_d is final.
          if (!pend) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_cnt_d == '0);
          end
        end
        S_DONE: begin
          if (!dut_start) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (issue) begin
        rd_en_q   <= 1'b1;
        rd_addr_q <= issue_addr;
        if (issue_addr == LAST_A) state_q <= S_DRAIN;
        else                      addr_q  <= issue_addr + A_WID'(1);
      end
    end
  end

  assign mem.rd_en   = rd_en_q;
  assign mem.rd_addr = rd_addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_cnt     = err_cnt_q;
  assign fail_valid  = fail_valid_q;
  assign fail_addr   = fail_addr_q;
  assign fail_data   = fail_data_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && mismatch)
      $display("bram_sweep_reader[%0d] t=%0t: mismatch addr=0x%0h data=0x%0h",
               ID, $time, tag_addr, mem.rd_dout);
  end
`endif

endmodule

// File: tb/tb_bram_sweep_reader.sv
// Directed bench: DUT A sweeps 0..15 with RD_LAT=2; DUT B sweeps the single
// address 0xA5A with RD_LAT=1. Cycle 0 is the cycle dut_start is sampled.
module tb_bram_sweep_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_start, a_en, a_inv, a_busy, a_done, a_pass, a_fv;
  logic [15:0] a_err;
  logic [11:0] a_faddr;
  logic [35:0] a_fdata;

  logic        b_start, b_en, b_inv, b_busy, b_done, b_pass, b_fv;
  logic [15:0] b_err;
  logic [11:0] b_faddr;
  logic [35:0] b_fdata;

  bram_sweep_reader_if #(.A_WID(12), .D_WID(36)) mif_a ();
  bram_sweep_reader_if #(.A_WID(12), .D_WID(36)) mif_b ();

  bram_sweep_reader #(
    .ID(0), .A_WID(12), .D_WID(36), .RD_LAT(2),
    .ADDR_FIRST(0), .ADDR_LAST(15), .ERR_WID(16)
  ) u_dut_a (
    .clk(clk), .rst(rst), .dut_start(a_start), .dut_enable(a_en),
    .pat_inv(a_inv), .mem(mif_a), .busy(a_busy), .done(a_done),
    .pass(a_pass), .err_cnt(a_err), .fail_valid(a_fv),
    .fail_addr(a_faddr), .fail_data(a_fdata)
  );

  bram_sweep_reader #(
    .ID(1), .A_WID(12), .D_WID(36), .RD_LAT(1),
    .ADDR_FIRST('hA5A), .ADDR_LAST('hA5A), .ERR_WID(16)
  ) u_dut_b (
    .clk(clk), .rst(rst), .dut_start(b_start), .dut_enable(b_en),
    .pat_inv(b_inv), .mem(mif_b), .busy(b_busy), .done(b_done),
    .pass(b_pass), .err_cnt(b_err), .fail_valid(b_fv),
    .fail_addr(b_faddr), .fail_data(b_fdata)
  );

  // Memory models with free-running output registers.
  logic [35:0] mem_a [0:4095];
  logic [35:0] a_s1, a_s2, b_s1;
  always @(posedge clk) begin
    a_s1 <= mem_a[mif_a.rd_addr];
    a_s2 <= a_s1;
    b_s1 <= (mif_b.rd_addr == 12'hA5A) ? 36'h0 : 36'hF_FFFF_FFFF;
  end
  assign mif_a.rd_dout = a_s2;
  assign mif_b.rd_dout = b_s1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_a_zero(input string tag);
    check_val({tag, "_ctl"},
              64'({a_busy, a_done, a_pass, a_fv, mif_a.rd_en, a_err,
                   mif_a.rd_addr, a_faddr}), 64'd0);
    check_val({tag, "_fdata"}, 64'(a_fdata), 64'd0);
  endtask

  // One full sweep on DUT A. Enable is low for cycles stall_s..stall_s+stall_l-1;
  // dut_start is dropped at cycle drop_at (ignored by the DUT mid-sweep).
  task automatic run_a(input string tag, input logic inv, input int stall_s,
                       input int stall_l, input int drop_at, input int exp_done,
                       input int exp_err, input logic exp_fv, input int exp_faddr,
                       input logic [35:0] exp_fdata, input logic exp_pass);
    int cyc = 0;
    int nrd = 0;
    int done_cyc = 0;
    logic seq_bad = 1'b0;
    @(negedge clk);
    a_inv   = inv;
    a_start = 1'b1;
    a_en    = !(stall_s <= 0 && 0 < stall_s + stall_l);
    while (cyc < 200 && done_cyc == 0) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 1) check_val({tag, "_busy_c1"}, 64'(a_busy), 64'd1);
      if (mif_a.rd_en) begin
        if (mif_a.rd_addr != 12'(nrd)) seq_bad = 1'b1;
        nrd++;
      end
      if (a_done) done_cyc = cyc;
      a_en = !(cyc >= stall_s && cyc < stall_s + stall_l);
      if (cyc == drop_at) a_start = 1'b0;
    end
    check_val({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_done));
    check_val({tag, "_nreads"}, 64'(nrd), 64'd16);
    check_val({tag, "_addr_seq_bad"}, 64'(seq_bad), 64'd0);
    check_val({tag, "_busy"}, 64'(a_busy), 64'd0);
    check_val({tag, "_pass"}, 64'(a_pass), 64'(exp_pass));
    check_val({tag, "_err_cnt"}, 64'(a_err), 64'(exp_err));
    check_val({tag, "_fail_valid"}, 64'(a_fv), 64'(exp_fv));
    check_val({tag, "_fail_addr"}, 64'(a_faddr), 64'(exp_faddr));
    check_val({tag, "_fail_data"}, 64'(a_fdata), 64'(exp_fdata));
    a_start = 1'b0;
    a_en    = 1'b1;
    repeat (2) @(negedge clk);
    check_val({tag, "_done_clr"}, 64'(a_done), 64'd0);
    check_val({tag, "_err_hold"}, 64'(a_err), 64'(exp_err));
  endtask

  initial begin
    int cyc;
    int nrd;
    int done_cyc;
    logic [11:0] got_addr;

    rst = 1'b1;
    a_start = 1'b0; a_en = 1'b1; a_inv = 1'b0;
    b_start = 1'b0; b_en = 1'b1; b_inv = 1'b0;
    for (int i = 0; i < 4096; i++) mem_a[i] = {36{i[0]}};
    repeat (3) @(negedge clk);
    check_a_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_a_zero("idle");

    run_a("good", 1'b0, 1000, 0, -1, 19, 0, 1'b0, 0, 36'h0, 1'b1);

    mem_a[5] = 36'h0_0000_0001;
    run_a("bad5", 1'b0, 1000, 0, -1, 19, 1, 1'b1, 5, 36'h0_0000_0001, 1'b0);
    mem_a[5] = 36'hF_FFFF_FFFF;

    run_a("inv", 1'b1, 1000, 0, 4, 19, 16, 1'b1, 0, 36'h0, 1'b0);

    run_a("stall", 1'b0, 5, 3, -1, 22, 0, 1'b0, 0, 36'h0, 1'b1);

    // Abort an inverted sweep at cycle 8; in-flight tags would mismatch if kept.
    @(negedge clk);
    a_inv   = 1'b1;
    a_start = 1'b1;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
    end
    check_val("rst_mid_busy", 64'(a_busy), 64'd1);
    rst     = 1'b1;
    a_start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_a_zero("rst_mid");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_val("rst_after_err", 64'(a_err), 64'd0);
    check_val("rst_after_fv", 64'(a_fv), 64'd0);
    check_val("rst_after_rden", 64'(mif_a.rd_en), 64'd0);

    run_a("post_rst", 1'b0, 1000, 0, -1, 19, 0, 1'b0, 0, 36'h0, 1'b1);

    // Single-address sweep on DUT B.
    cyc = 0; nrd = 0; done_cyc = 0; got_addr = '0;
    @(negedge clk);
    b_start = 1'b1;
    while (cyc < 20 && done_cyc == 0) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (mif_b.rd_en) begin
        nrd++;
        got_addr = mif_b.rd_addr;
      end
      if (b_done) done_cyc = cyc;
    end
    check_val("single_done_cycle", 64'(done_cyc), 64'd3);
    check_val("single_nreads", 64'(nrd), 64'd1);
    check_val("single_addr", 64'(got_addr), 64'hA5A);
    check_val("single_pass", 64'(b_pass), 64'd1);
    check_val("single_err", 64'(b_err), 64'd0);
    check_val("single_fv", 64'(b_fv), 64'd0);
    b_start = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bram_sweep_reader.md
# bram_sweep_reader

Read-side checker for the cascaded true-dual-port BRAM power test: after a writer has filled a BRAM range with an address-parity checkerboard, this block sweeps the range through one read port. It compares every returned word against the expected pattern and reports pass/fail, an error count and the first failing address. It sits beside the BRAM instance in the power-analysis harness and shares the harness start/enable/pass signalling.

## Interface
- `ID`, 0: instance number used in simulation messages.
- `A_WID`, 12: address width.
- `D_WID`, 36: data width.
- `RD_LAT`, 2: memory read latency in cycles; legal range 1..3.
- `ADDR_FIRST`, 0: first address swept.
- `ADDR_LAST`, 2**A_WID-1: last address swept; must be >= `ADDR_FIRST`.
- `ERR_WID`, 16: error counter width.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `dut_start` in 1: level start request.
- `dut_enable` in 1: issue enable; 0 stalls read issue.
- `pat_inv` in 1: pattern polarity; latched at sweep start.
- `rd_en` out 1: memory read enable.
- `rd_addr` out A_WID: memory read address.
- `rd_dout` in D_WID: memory read data, valid RD_LAT cycles after issue.
- `busy` out 1: sweep or drain in progress.
- `done` out 1: sweep complete; results valid.
- `pass` out 1: done with zero errors.
- `err_cnt` out ERR_WID: saturating mismatch count.
- `fail_valid` out 1: at least one mismatch recorded.
- `fail_addr` out A_WID: address of the first mismatch.
- `fail_data` out D_WID: data of the first mismatch.

## Operation
- Expected word for address a: all bits equal to `a[0] ^ pat_inv_latched`. That is, all-zeros or all-ones (0x000000000 / 0xFFFFFFFFF at D_WID=36).
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE:
  - `rd_en`=0.
  - `dut_start`=1 does all of: latch `pat_inv`; set addr=`ADDR_FIRST`; clear `err_cnt`, `fail_*` and `pass`; go to SWEEP.
- SWEEP, when `dut_enable`=1 in a cycle:
  - issue one read (`rd_en`=1, `rd_addr`=addr);
  - push {valid, addr} into the tag pipe;
  - addr += 1.
  - After issuing `ADDR_LAST`, go to DRAIN.
- SWEEP, when `dut_enable`=0 in a cycle:
  - `rd_en`=0 and no push.
  - Tags already in flight keep advancing. The memory output register is free-running, so its data path is never stalled.
- DRAIN: wait until the tag pipe is empty, then go to DONE.
- DONE:
  - `done`=1 and `pass`=(`err_cnt`==0).
  - Stay in DONE while `dut_start`=1; return to IDLE when `dut_start`=0.
  - A new sweep requires `dut_start` to be deasserted and then reasserted.
- Compare, when a valid tag exits the pipe: if `rd_dout` != expected:
  - `err_cnt` += 1, saturating at all-ones;
  - if `fail_valid`=0, capture `fail_addr`/`fail_data` and set `fail_valid`;
  - simulation `$display` of ID, time, addr, data.
- Deasserting `dut_start` during SWEEP or DRAIN is ignored; the sweep runs to completion.
- Single-address range (`ADDR_FIRST`==`ADDR_LAST`): exactly one read, then DRAIN.
- The address counter never wraps past `ADDR_LAST`; the sweep ends there.

## Timing
- All outputs are registered.
- Reset values: `rd_en` 0, `rd_addr` 0, `busy` 0, `done` 0, `pass` 0, `err_cnt` 0, `fail_valid` 0, `fail_addr` 0, `fail_data` 0. Tag pipe cleared, state IDLE.
- Reset mid-sweep aborts immediately. In-flight data is discarded; the next cycle shows the reset values.
- Cycle 0: `dut_start` sampled high in IDLE. Cycle 1: first `rd_en`/`rd_addr`; `busy`=1.
- A read issued in cycle k is compared at the end of cycle k+RD_LAT. The resulting `err_cnt`/`fail_*` update is visible in cycle k+RD_LAT+1.
- With `dut_enable` held at 1 and N=`ADDR_LAST`-`ADDR_FIRST`+1:
  - last issue in cycle N;
  - `busy` falls and `done`/`pass` rise in cycle N+RD_LAT+1.
- Each stall cycle delays completion by exactly one cycle.
- `err_cnt` is final and stable whenever `done`=1.

## Structure
- Package `bram_sweep_pkg` holds:
  - the state enum (IDLE/SWEEP/DRAIN/DONE);
  - the `ERR_WID` default;
  - function `expected_word(addr_lsb, inv)` returning the D_WID pattern.
- One sub-module, `bram_rd_tag_pipe`: an RD_LAT-deep shift register of {valid, addr}, advancing every cycle, with synchronous clear.

## Test plan
- Range 0..15, memory preloaded with the checkerboard, `pat_inv`=0, RD_LAT=2 -> 16 reads; `done`=1 in cycle 19; `pass`=1; `err_cnt`=0; `fail_valid`=0.
- Same memory but word 5 corrupted to 0x000000001 -> `err_cnt`=1; `fail_addr`=5; `fail_data`=0x000000001; `pass`=0.
- Checkerboard preload, `pat_inv`=1 -> every read mismatches: `err_cnt`=16; `fail_addr`=0; `fail_data`=0x000000000.
- `dut_enable` low for 3 cycles mid-sweep -> exactly 16 reads, no duplicated or skipped addresses; `done` in cycle 22.
- `rst` pulsed at cycle 8 of a sweep -> all outputs zero next cycle; a subsequent `dut_start` runs a clean full sweep with `pass`=1.
- Single address (`ADDR_FIRST`=`ADDR_LAST`=0xA5A), RD_LAT=1, good data 0x000000000 -> one `rd_en` pulse; `done` in cycle 3; `pass`=1.
